// File: rtl/global_types_pkg.sv
// Shared pipeline types: control bundle carried between decode and execute,
// result-select encodings and the stall-watchdog state encoding.
package global_types;

    localparam logic [1:0] SEL_RESULT_ALU = 2'd0;
    localparam logic [1:0] SEL_RESULT_MEM = 2'd1;
    localparam logic [1:0] SEL_RESULT_PC4 = 2'd2;
    localparam logic [1:0] SEL_RESULT_IMM = 2'd3;

    typedef struct packed {
        logic       rf_we;
        logic       dm_we;
        logic [1:0] sel_result;
        logic [3:0] alu_ctrl;
        logic       sel_alu_b;
        logic       sel_wa;
    } de_ctrl_t;

    localparam de_ctrl_t DE_CTRL_BUBBLE = '0;

    typedef enum logic {
        WD_RUN     = 1'b0,
        WD_STALLED = 1'b1
    } wd_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with flush-to-bubble, hold, saturating
// performance counters and a watchdog on long flush/hold runs.
module decode_execute_register
    import global_types::*;
#(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_flush,
    input  logic              e_hold,
    input  logic              d_valid,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic [4:0]        d_rd,
    input  logic [DATA_W-1:0] d_rd0,
    input  logic [DATA_W-1:0] d_rd1,
    input  logic [DATA_W-1:0] d_imm,
    input  de_ctrl_t          d_ctrl,
    output logic              e_valid,
    output logic [4:0]        e_rs,
    output logic [4:0]        e_rt,
    output logic [4:0]        e_rd,
    output logic [DATA_W-1:0] e_rd0,
    output logic [DATA_W-1:0] e_rd1,
    output logic [DATA_W-1:0] e_imm,
    output de_ctrl_t          e_ctrl,
    output logic [1:0]        e_sel_result,
    output logic [CNT_W-1:0]  cnt_issued,
    output logic [CNT_W-1:0]  cnt_bubbles,
    output logic [CNT_W-1:0]  cnt_hold,
    output logic              stall_timeout
);

    localparam int RL_W = $clog2(MAX_STALL + 2);
    localparam logic [RL_W-1:0] RL_SAT = RL_W'(MAX_STALL + 1);
    localparam logic [RL_W-1:0] RL_LIM = RL_W'(MAX_STALL);

    logic              valid_q, valid_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d, imm_q, imm_d;
    de_ctrl_t          ctrl_q, ctrl_d;

    wd_state_e         state_q, state_d;
    logic [RL_W-1:0]   run_len_q, run_len_d;
    logic              timeout_q, timeout_d;

    logic stall;
    logic capture;

    assign stall   = e_flush | e_hold;
    assign capture = ~e_flush & ~e_hold;

    // Flush clears every field, so a bubble shows e_rt=0 and cannot match a
    // load-use compare in the hazard controller.
    always_comb begin
        valid_d = valid_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        if (e_flush) begin
            valid_d = 1'b0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            rd0_d   = '0;
            rd1_d   = '0;
            imm_d   = '0;
            ctrl_d  = DE_CTRL_BUBBLE;
        end else if (!e_hold) begin
            valid_d = d_valid;
            rs_d    = d_rs;
            rt_d    = d_rt;
            rd_d    = d_rd;
            rd0_d   = d_rd0;
            rd1_d   = d_rd1;
            imm_d   = d_imm;
            ctrl_d  = d_valid ? d_ctrl : DE_CTRL_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= DE_CTRL_BUBBLE;
        end else begin
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // run_len counts consecutive flush/hold cycles, pinned one past the limit.
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        timeout_d = timeout_q;
        unique case (state_q)
            WD_RUN: begin
                if (stall) begin
                    state_d   = WD_STALLED;
                    run_len_d = RL_W'(1);
                end
            end
            WD_STALLED: begin
                if (stall) begin
                    if (run_len_q != RL_SAT) run_len_d = run_len_q + RL_W'(1);
                end else begin
                    state_d   = WD_RUN;
                    run_len_d = '0;
                end
            end
            default: begin
                state_d   = WD_RUN;
                run_len_d = '0;
            end
        endcase
        if (run_len_d > RL_LIM) timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WD_RUN;
            run_len_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_issued (
        .clk   (clk),
        .reset (reset),
        .inc   (capture & d_valid),
        .count (cnt_issued)
    );

    sat_counter #(.W(CNT_W)) u_cnt_bubbles (
        .clk   (clk),
        .reset (reset),
        .inc   (e_flush),
        .count (cnt_bubbles)
    );

    sat_counter #(.W(CNT_W)) u_cnt_hold (
        .clk   (clk),
        .reset (reset),
        .inc   (e_hold & ~e_flush),
        .count (cnt_hold)
    );

    assign e_valid       = valid_q;
    assign e_rs          = rs_q;
    assign e_rt          = rt_q;
    assign e_rd          = rd_q;
    assign e_rd0         = rd0_q;
    assign e_rd1         = rd1_q;
    assign e_imm         = imm_q;
    assign e_ctrl        = ctrl_q;
    assign e_sel_result  = ctrl_q.sel_result;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_decode_execute_register.sv
// Scoreboard bench: driver predicts each edge's outcome from a behavioural
// model and queues it; a monitor checks the DUT after every rising edge.
module tb_decode_execute_register;
    import global_types::*;

    localparam int DATA_W    = 32;
    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset, e_flush, e_hold, d_valid;
    logic [4:0]        d_rs, d_rt, d_rd;
    logic [DATA_W-1:0] d_rd0, d_rd1, d_imm;
    de_ctrl_t          d_ctrl;
    logic              e_valid;
    logic [4:0]        e_rs, e_rt, e_rd;
    logic [DATA_W-1:0] e_rd0, e_rd1, e_imm;
    de_ctrl_t          e_ctrl;
    logic [1:0]        e_sel_result;
    logic [CNT_W-1:0]  cnt_issued, cnt_bubbles, cnt_hold;
    logic              stall_timeout;

    decode_execute_register #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .reset(reset), .e_flush(e_flush), .e_hold(e_hold),
        .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
        .d_rd0(d_rd0), .d_rd1(d_rd1), .d_imm(d_imm), .d_ctrl(d_ctrl),
        .e_valid(e_valid), .e_rs(e_rs), .e_rt(e_rt), .e_rd(e_rd),
        .e_rd0(e_rd0), .e_rd1(e_rd1), .e_imm(e_imm), .e_ctrl(e_ctrl),
        .e_sel_result(e_sel_result), .cnt_issued(cnt_issued),
        .cnt_bubbles(cnt_bubbles), .cnt_hold(cnt_hold),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              valid;
        logic [4:0]        rs, rt, rd;
        logic [DATA_W-1:0] rd0, rd1, imm;
        de_ctrl_t          ctrl;
        int                iss, bub, hld;
        logic              to;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   stall_run;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Apply one cycle of inputs, then predict what the next edge produces.
    task automatic step(input logic rst, input logic fl, input logic hd, input logic vl,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] im, input de_ctrl_t c);
        @(negedge clk);
        reset = rst; e_flush = fl; e_hold = hd; d_valid = vl;
        d_rs = rs; d_rt = rt; d_rd = rd; d_rd0 = a; d_rd1 = b; d_imm = im; d_ctrl = c;
        if (rst) begin
            m = '{valid: 1'b0, rs: '0, rt: '0, rd: '0, rd0: '0, rd1: '0, imm: '0,
                  ctrl: '0, iss: 0, bub: 0, hld: 0, to: 1'b0};
            stall_run = 0;
        end else begin
            stall_run = (fl || hd) ? stall_run + 1 : 0;
            if (stall_run > MAX_STALL) m.to = 1'b1;
            if (fl) begin
                m.valid = 1'b0; m.rs = '0; m.rt = '0; m.rd = '0;
                m.rd0 = '0; m.rd1 = '0; m.imm = '0; m.ctrl = '0;
                m.bub = sat_inc(m.bub);
            end else if (hd) begin
                m.hld = sat_inc(m.hld);
            end else begin
                m.valid = vl; m.rs = rs; m.rt = rt; m.rd = rd;
                m.rd0 = a; m.rd1 = b; m.imm = im;
                m.ctrl = vl ? c : '0;
                if (vl) m.iss = sat_inc(m.iss);
            end
        end
        exp_q.push_back(m);
    endtask

    task automatic rand_step(input int p_rst, input int p_fl, input int p_hd, input int p_vl);
        logic [9:0] cbits;
        cbits = 10'($urandom);
        step($urandom_range(0, 99) < p_rst, $urandom_range(0, 99) < p_fl,
             $urandom_range(0, 99) < p_hd, $urandom_range(0, 99) < p_vl,
             5'($urandom), 5'($urandom), 5'($urandom),
             $urandom, $urandom, $urandom, de_ctrl_t'(cbits));
    endtask

    // Monitor: every edge the DUT presents a new execute slot.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("e_valid", 64'(e_valid), 64'(e.valid));
                check("e_rs", 64'(e_rs), 64'(e.rs));
                check("e_rt", 64'(e_rt), 64'(e.rt));
                check("e_rd", 64'(e_rd), 64'(e.rd));
                check("e_rd0", 64'(e_rd0), 64'(e.rd0));
                check("e_rd1", 64'(e_rd1), 64'(e.rd1));
                check("e_imm", 64'(e_imm), 64'(e.imm));
                check("e_ctrl", 64'(e_ctrl), 64'(e.ctrl));
                check("e_sel_result", 64'(e_sel_result), 64'(e.ctrl.sel_result));
                check("cnt_issued", 64'(cnt_issued), 64'(e.iss));
                check("cnt_bubbles", 64'(cnt_bubbles), 64'(e.bub));
                check("cnt_hold", 64'(cnt_hold), 64'(e.hld));
                check("stall_timeout", 64'(stall_timeout), 64'(e.to));
            end
        end
    end

    initial begin
        de_ctrl_t c0, cw, cd;
        c0 = '0;
        cw = '0; cw.rf_we = 1'b1; cw.sel_result = SEL_RESULT_MEM;
        cd = '0; cd.dm_we = 1'b1; cd.alu_ctrl = 4'h6;
        m = '{valid: 1'b0, rs: '0, rt: '0, rd: '0, rd0: '0, rd1: '0, imm: '0,
              ctrl: '0, iss: 0, bub: 0, hld: 0, to: 1'b0};
        stall_run = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c0);
        // Plain capture, then flush over a store.
        step(0, 0, 0, 1, 3, 5, 7, 32'h1234, 32'h55, 32'hFFFF_FFF0, cw);
        step(0, 1, 0, 1, 9, 10, 11, 32'hAAAA, 32'hBBBB, 32'hCCCC, cd);
        step(0, 0, 0, 1, 3, 5, 7, 32'h1234, 32'h55, 32'h4, cw);
        // Three-cycle hold with changing decode inputs, then release.
        for (int i = 0; i < 3; i++) rand_step(0, 0, 100, 100);
        step(0, 0, 0, 1, 1, 2, 3, 32'hDEAD, 32'hBEEF, 32'h10, cw);
        step(0, 0, 0, 0, 4, 6, 8, 32'h1, 32'h2, 32'h3, cw);
        // Flush and hold together.
        step(0, 1, 1, 1, 12, 13, 14, 32'h77, 32'h88, 32'h99, cw);
        step(0, 0, 0, 1, 2, 4, 6, 32'h5, 32'h6, 32'h7, cd);
        // Four stall cycles stay legal; five trip the watchdog.
        for (int i = 0; i < 4; i++) rand_step(0, 0, 100, 100);
        step(0, 0, 0, 1, 1, 1, 1, 32'h1, 32'h1, 32'h1, cw);
        for (int i = 0; i < 5; i++) rand_step(0, 30, 100, 100);
        for (int i = 0; i < 3; i++) rand_step(0, 0, 0, 100);
        step(1, 0, 0, 1, 1, 1, 1, 32'h1, 32'h1, 32'h1, cw);
        // Saturation: 20 valid captures on a 4-bit counter, then reset.
        for (int i = 0; i < 20; i++) rand_step(0, 0, 0, 100);
        for (int i = 0; i < 20; i++) rand_step(0, 100, 0, 100);
        for (int i = 0; i < 3; i++) rand_step(0, 0, 0, 100);
        step(1, 0, 0, 1, 1, 1, 1, 32'h1, 32'h1, 32'h1, cw);
        for (int i = 0; i < 2000; i++) rand_step(2, 15, 20, 70);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c0);

        @(posedge clk); #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        if (!done) begin
            $display("FAIL watchdog: bench did not finish, got running expected done");
            $fatal(1);
        end
    end

endmodule
